ram_dump_tx: RTL and testbench
==============================

// Module: ram_dump_tx
// PURPOSE
//  Reads a block of words from RAM over the shared read port and streams them out byte-wise on the
//  AXI-stream TX path toward the UART. This is the reverse of the boot loader: it uploads memory to the host
//  instead of downloading into it. Sits beside bios; the top level muxes its RAM read port and UART TX stream.
// PARAMETERS
//  HEADER_EN    1     1: prefix each dump with 0xA5, count[7:0], count[15:8]; 0: data bytes only
//  HEADER_BYTE  8'hA5 value of the first header byte
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset; synchronous, active-high
//  clk_en        in   1   clock enable; state, counters and outputs update only when 1
//  i_start       in   1   start a dump; sampled in IDLE only
//  i_base_addr   in   32  byte address of first word; bits [1:0] ignored (treated as 0)
//  i_word_count  in   16  number of 32-bit words to send; 0 allowed
//  o_busy        out  1   1 from the cycle after start is accepted until the DONE state is entered
//  o_done        out  1   one-cycle pulse when the dump completes
//  o_read_req    out  1   RAM read request
//  o_read_addr   out  32  RAM read byte address, word aligned
//  i_read_data   in   32  RAM read data, valid exactly 1 enabled cycle after o_read_req
//  o_data        out  8   TX stream byte
//  o_valid       out  1   TX stream valid
//  i_out_ready   in   1   TX stream ready from UART
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal address/count/byte index cleared.
//  All transitions below happen only on clk edges with clk_en=1; with clk_en=0, every register holds.
//  Handshake: a byte transfers when o_valid & i_out_ready & clk_en. While o_valid=1 without a transfer,
//   o_data stays stable and o_valid stays 1. o_valid never depends combinationally on i_out_ready.
//  States:
//   IDLE: on i_start, latch {i_base_addr[31:2],2'b00} into addr and i_word_count into remaining.
//         -> HDR if HEADER_EN, else -> REQ; if remaining==0 and !HEADER_EN -> DONE.
//   HDR:  send HEADER_BYTE, count[7:0], count[15:8] in order, one transfer each.
//         After the third transfer: -> DONE if count==0, else -> REQ.
//   REQ:  o_read_req=1, o_read_addr=addr for exactly one enabled cycle -> WAIT.
//   WAIT: capture i_read_data into a 32-bit shift register; byte index=0 -> SEND.
//   SEND: o_data=word[8*idx+:8], little-endian (byte 0 first). Each transfer increments idx.
//         After idx==3 transfers: addr+=4 and remaining-=1. Then -> DONE if remaining becomes 0, else -> REQ.
//   DONE: o_done=1 for one enabled cycle; o_busy=0 -> IDLE.
//  o_read_req is 0 in every state other than REQ. o_valid is 1 only in HDR and SEND.
//  At most one RAM read is outstanding. There is no prefetch: the next read is issued only after byte 3 transfers.
//  Throughput bound: 4 bytes per 2+4 enabled cycles when ready is held at 1.
//  Address arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
//  Count is 16 bits unsigned; 0xFFFF words is the maximum dump size.
//  i_start while busy, or in DONE, is ignored (no queueing). i_base_addr and i_word_count are only sampled at start.
//  Reset mid-dump: abort immediately. o_valid and o_read_req are 0 the cycle after reset is seen; no done pulse.
//  i_read_data is sampled only in WAIT. RAM data outside that cycle is don't-care.
// TESTING
//  1 HEADER_EN=1, base=0x100, count=2; RAM[0x100]=0x44332211, RAM[0x104]=0xDDCCBBAA, ready=1
//    -> bytes A5 02 00 11 22 33 44 AA BB CC DD; one o_done pulse; read addrs 0x100, 0x104.
//  2 HEADER_EN=1, count=0 -> bytes A5 00 00; no o_read_req ever asserted; o_done pulse.
//    With HEADER_EN=0: no bytes are sent and o_done pulses the cycle after start.
//  3 Backpressure: random i_out_ready, plus clk_en toggled 1-of-3 -> identical byte sequence to test 1.
//    o_data stays stable while valid & !ready; no byte is duplicated or dropped.
//  4 Wrap: base=0xFFFF_FFFE, count=2 -> read addrs 0xFFFF_FFFC then 0x0000_0000.
//  5 Assert rst during byte 2 of word 0 -> o_valid=0 next cycle; no o_done.
//    A new start then replays from the header.
//  6 Pulse i_start with base=0x200 during an active dump -> ignored; the original dump is completed unchanged.

Source files
------------

// File: rtl/ram_dump_tx_if.sv
// Bus bundle for ram_dump_tx: start/status, shared RAM read port and byte-wide TX stream.
// The master side is the dump engine; the slave side is the top level/RAM/UART.
interface ram_dump_tx_if;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [15:0] i_word_count;
    logic        o_busy;
    logic        o_done;
    logic        o_read_req;
    logic [31:0] o_read_addr;
    logic [31:0] i_read_data;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_out_ready;

    modport master (
        input  i_start, i_base_addr, i_word_count, i_read_data, i_out_ready,
        output o_busy, o_done, o_read_req, o_read_addr, o_data, o_valid
    );

    modport slave (
        output i_start, i_base_addr, i_word_count, i_read_data, i_out_ready,
        input  o_busy, o_done, o_read_req, o_read_addr, o_data, o_valid
    );
endinterface

// File: rtl/ram_dump_tx.sv
// Uploads a block of RAM words to the UART TX stream, byte by byte, little-endian,
// optionally prefixed with a 3-byte header carrying the word count.
module ram_dump_tx #(
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    ram_dump_tx_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [31:0] addr, addr_n;
    logic [31:0] word, word_n;
    logic [15:0] remaining, remaining_n;
    logic [15:0] count, count_n;
    logic [1:0]  idx, idx_n;
    logic        valid;
    logic        xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            word      <= '0;
            remaining <= '0;
            count     <= '0;
            idx       <= '0;
        end else if (clk_en) begin
            state     <= state_n;
            addr      <= addr_n;
            word      <= word_n;
            remaining <= remaining_n;
            count     <= count_n;
            idx       <= idx_n;
        end
    end

    // valid is a pure function of state, so it never waits on ready
    assign valid = (state == S_HDR) || (state == S_SEND);
    assign xfer  = valid && bus.i_out_ready;

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        word_n      = word;
        remaining_n = remaining;
        count_n     = count;
        idx_n       = idx;
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    addr_n      = bus.i_base_addr & 32'hFFFF_FFFC;
                    remaining_n = bus.i_word_count;
                    count_n     = bus.i_word_count;
                    idx_n       = '0;
                    if (HEADER_EN)
                        state_n = S_HDR;
                    else if (bus.i_word_count == 16'd0)
                        state_n = S_DONE;
                    else
                        state_n = S_REQ;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (idx == 2'd2) begin
                        idx_n   = '0;
                        state_n = (count == 16'd0) ? S_DONE : S_REQ;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            S_REQ:  state_n = S_WAIT;
            S_WAIT: begin
                word_n  = bus.i_read_data;
                idx_n   = '0;
                state_n = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) begin
                        addr_n      = addr + 32'd4;
                        remaining_n = remaining - 16'd1;
                        state_n     = (remaining == 16'd1) ? S_DONE : S_REQ;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_valid     = valid;
        bus.o_read_req  = (state == S_REQ);
        bus.o_read_addr = (state == S_REQ) ? addr : '0;
        bus.o_busy      = (state != S_IDLE) && (state != S_DONE);
        bus.o_done      = (state == S_DONE);
        bus.o_data      = '0;
        if (state == S_HDR) begin
            case (idx)
                2'd0:    bus.o_data = HEADER_BYTE;
                2'd1:    bus.o_data = count[7:0];
                default: bus.o_data = count[15:8];
            endcase
        end else if (state == S_SEND) begin
            bus.o_data = word[{idx, 3'b000} +: 8];
        end
    end
endmodule

// File: tb/tb_ram_dump_tx.sv
// Randomized self-checking bench for ram_dump_tx: a queue-based byte/address model built
// from the dump rules, checked every cycle, plus literal expectations for the key scenarios.
module tb_ram_dump_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;

    ram_dump_tx_if bif ();
    ram_dump_tx_if bif2 ();

    ram_dump_tx #(.HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bif)
    );

    ram_dump_tx #(.HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)) dut_nohdr (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bif2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int xfer_cnt = 0;
    int busy_cycles = 0;
    bit rand_mode = 1'b0;
    logic ready_seq = 1'b1;

    logic [31:0] mem [logic [31:0]];
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_addr [$];
    logic [7:0]  cap_bytes [$];
    logic [31:0] cap_addr [$];
    logic [7:0]  lit1 [11] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0]  lit2 [4] = '{8'h21, 8'h43, 8'h65, 8'h87};

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected stream for one accepted start, straight from the dump format
    task automatic model_push(input logic [31:0] base, input logic [15:0] cnt);
        logic [31:0] a;
        logic [31:0] w;
        a = base & 32'hFFFF_FFFC;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(cnt[7:0]);
        exp_bytes.push_back(cnt[15:8]);
        for (int unsigned i = 0; i < 32'(cnt); i++) begin
            exp_addr.push_back(a);
            w = ram_word(a);
            for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
            a = a + 32'd4;
        end
    endtask

    // RAM: data valid one enabled cycle after the request, junk otherwise
    always @(posedge clk) begin
        if (clk_en && bif.o_read_req) bif.i_read_data <= ram_word(bif.o_read_addr);
        else if (clk_en) bif.i_read_data <= $urandom;
        if (clk_en && bif2.o_read_req) bif2.i_read_data <= ram_word(bif2.o_read_addr);
    end

    // Ready / clock-enable driver, applied #2 after each rising edge
    always @(posedge clk) begin
        #2;
        if (rand_mode) begin
            bif.i_out_ready = 1'($urandom_range(1));
            clk_en = ($urandom_range(2) != 0);
        end else begin
            bif.i_out_ready = ready_seq;
            clk_en = 1'b1;
        end
    end

    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(bif.o_valid), 32'd1);
                check("hold_data", 32'(bif.o_data), 32'(hold_d));
            end
            check("valid_req_exclusive", 32'(bif.o_valid & bif.o_read_req), 32'd0);
            if (clk_en && bif.o_busy) busy_cycles++;
            if (clk_en && bif.o_valid && bif.i_out_ready) begin
                xfer_cnt++;
                cap_bytes.push_back(bif.o_data);
                check("byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
                if (exp_bytes.size() != 0) check("byte_value", 32'(bif.o_data), 32'(exp_bytes.pop_front()));
            end
            if (clk_en && bif.o_read_req) begin
                cap_addr.push_back(bif.o_read_addr);
                check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) check("read_addr", bif.o_read_addr, exp_addr.pop_front());
            end
            if (clk_en && bif.o_done) begin
                done_cnt++;
                check("done_bytes_left", 32'(exp_bytes.size()), 32'd0);
                check("done_reads_left", 32'(exp_addr.size()), 32'd0);
            end
            hold_v = bif.o_valid && !(bif.i_out_ready && clk_en);
            hold_d = bif.o_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds start until an enabled edge has sampled it, then scrambles the operands
    task automatic start_dump(input logic [31:0] base, input logic [15:0] cnt, input bit model);
        bit en;
        int k;
        bif.i_base_addr = base;
        bif.i_word_count = cnt;
        bif.i_start = 1'b1;
        if (model) begin
            model_push(base, cnt);
            exp_done++;
        end
        k = 0;
        do begin
            @(negedge clk);
            en = clk_en;
            @(posedge clk);
            #1;
            k++;
        end while (!en && k < 100);
        bif.i_start = 1'b0;
        bif.i_base_addr = $urandom;
        bif.i_word_count = 16'($urandom);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_cnt < exp_done && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic check_lit1(input string name);
        check({name, "_len"}, 32'(cap_bytes.size()), 32'd11);
        for (int i = 0; i < 11 && i < cap_bytes.size(); i++)
            check({name, "_byte"}, 32'(cap_bytes[i]), 32'(lit1[i]));
        check({name, "_nreads"}, 32'(cap_addr.size()), 32'd2);
        if (cap_addr.size() == 2) begin
            check({name, "_addr0"}, cap_addr[0], 32'h0000_0100);
            check({name, "_addr1"}, cap_addr[1], 32'h0000_0104);
        end
    endtask

    initial begin
        int k, x0, d0;
        bit seen_done;
        logic [7:0] got2 [$];
        logic [31:0] addr2 [$];

        bif.i_start = 1'b0;
        bif.i_base_addr = '0;
        bif.i_word_count = '0;
        bif.i_out_ready = 1'b1;
        bif2.i_start = 1'b0;
        bif2.i_base_addr = '0;
        bif2.i_word_count = '0;
        bif2.i_out_ready = 1'b1;
        bif2.i_read_data = '0;
        mem[32'h0000_0100] = 32'h4433_2211;
        mem[32'h0000_0104] = 32'hDDCC_BBAA;
        mem[32'h0000_0300] = 32'h8765_4321;

        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 32'(bif.o_valid), 32'd0);
        check("rst_read_req", 32'(bif.o_read_req), 32'd0);
        check("rst_done", 32'(bif.o_done), 32'd0);
        check("rst_busy", 32'(bif.o_busy), 32'd0);
        check("rst_data", 32'(bif.o_data), 32'd0);
        check("rst_read_addr", bif.o_read_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Basic two-word dump with header, ready held high
        cap_bytes.delete();
        cap_addr.delete();
        busy_cycles = 0;
        start_dump(32'h0000_0100, 16'd2, 1'b1);
        check("t1_busy_after_start", 32'(bif.o_busy), 32'd1);
        wait_done("t1_done");
        check_lit1("t1");
        check("t1_busy_cycles", 32'(busy_cycles), 32'd15);

        // Zero-length dump: header only, no reads
        cap_bytes.delete();
        cap_addr.delete();
        start_dump(32'h0000_0040, 16'd0, 1'b1);
        wait_done("t2_done");
        check("t2_len", 32'(cap_bytes.size()), 32'd3);
        if (cap_bytes.size() == 3) begin
            check("t2_b0", 32'(cap_bytes[0]), 32'hA5);
            check("t2_b1", 32'(cap_bytes[1]), 32'h00);
            check("t2_b2", 32'(cap_bytes[2]), 32'h00);
        end
        check("t2_no_reads", 32'(cap_addr.size()), 32'd0);

        // Headerless instance, zero length: done the cycle after start
        bif2.i_word_count = 16'd0;
        bif2.i_start = 1'b1;
        tick();
        bif2.i_start = 1'b0;
        @(negedge clk);
        check("nohdr0_done", 32'(bif2.o_done), 32'd1);
        check("nohdr0_valid", 32'(bif2.o_valid), 32'd0);
        check("nohdr0_busy", 32'(bif2.o_busy), 32'd0);
        @(negedge clk);
        check("nohdr0_done_clear", 32'(bif2.o_done), 32'd0);

        // Headerless instance, one word, unaligned base
        tick();
        bif2.i_base_addr = 32'h0000_0301;
        bif2.i_word_count = 16'd1;
        bif2.i_start = 1'b1;
        tick();
        bif2.i_start = 1'b0;
        seen_done = 1'b0;
        k = 0;
        while (!seen_done && k < 40) begin
            @(negedge clk);
            if (bif2.o_valid && bif2.i_out_ready) got2.push_back(bif2.o_data);
            if (bif2.o_read_req) addr2.push_back(bif2.o_read_addr);
            if (bif2.o_done) seen_done = 1'b1;
            k++;
        end
        check("nohdr1_done", 32'(seen_done), 32'd1);
        check("nohdr1_len", 32'(got2.size()), 32'd4);
        for (int i = 0; i < 4 && i < got2.size(); i++) check("nohdr1_byte", 32'(got2[i]), 32'(lit2[i]));
        check("nohdr1_nreads", 32'(addr2.size()), 32'd1);
        if (addr2.size() == 1) check("nohdr1_addr", addr2[0], 32'h0000_0300);
        tick();

        // Backpressure and clock-enable gaps: same stream as the basic dump
        cap_bytes.delete();
        cap_addr.delete();
        rand_mode = 1'b1;
        start_dump(32'h0000_0100, 16'd2, 1'b1);
        wait_done("t3_done");
        check_lit1("t3");
        for (int n = 0; n < 4; n++) begin
            start_dump($urandom, 16'($urandom_range(1, 3)), 1'b1);
            wait_done("rand_done");
        end
        rand_mode = 1'b0;
        repeat (2) tick();

        // Address wrap past the top of memory
        cap_addr.delete();
        start_dump(32'hFFFF_FFFE, 16'd2, 1'b1);
        wait_done("t4_done");
        check("t4_nreads", 32'(cap_addr.size()), 32'd2);
        if (cap_addr.size() == 2) begin
            check("t4_addr0", cap_addr[0], 32'hFFFF_FFFC);
            check("t4_addr1", cap_addr[1], 32'h0000_0000);
        end

        // Reset while byte 2 of word 0 is on the bus
        x0 = xfer_cnt;
        start_dump(32'h0000_0100, 16'd2, 1'b1);
        exp_done--;
        k = 0;
        while (xfer_cnt < x0 + 5 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("t5_reached_byte2", 32'(xfer_cnt), 32'(x0 + 5));
        check("t5_byte2_valid", 32'(bif.o_valid), 32'd1);
        check("t5_byte2_data", 32'(bif.o_data), 32'h33);
        ready_seq = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_valid_after_rst", 32'(bif.o_valid), 32'd0);
        check("t5_req_after_rst", 32'(bif.o_read_req), 32'd0);
        check("t5_busy_after_rst", 32'(bif.o_busy), 32'd0);
        rst = 1'b0;
        ready_seq = 1'b1;
        exp_bytes.delete();
        exp_addr.delete();
        d0 = done_cnt;
        repeat (10) tick();
        check("t5_no_done", 32'(done_cnt), 32'(d0));
        cap_bytes.delete();
        cap_addr.delete();
        start_dump(32'h0000_0100, 16'd2, 1'b1);
        wait_done("t5_replay_done");
        check_lit1("t5_replay");

        // Start pulse during an active dump is ignored
        cap_bytes.delete();
        cap_addr.delete();
        x0 = xfer_cnt;
        start_dump(32'h0000_0100, 16'd2, 1'b1);
        k = 0;
        while (xfer_cnt < x0 + 4 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        start_dump(32'h0000_0200, 16'd5, 1'b0);
        wait_done("t6_done");
        repeat (20) tick();
        check_lit1("t6");
        check("final_done_count", 32'(done_cnt), 32'(exp_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
